// File: rtl/imem_boot_loader.sv
// imem_boot_loader: byte-stream program loader that fills instruction memory and
// holds the core in reset until the load completes.
// Optional trailing XOR checksum byte is enabled by defining LOADER_CHECKSUM_EN.
module imem_boot_loader #(
   parameter int ADDR_W = 20
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_start,
   input  logic [7:0]        i_rx_data,
   input  logic              i_rx_valid,
   output logic              o_rx_ready,
   output logic              o_imem_we,
   output logic [ADDR_W-1:0] o_imem_addr,
   output logic [15:0]       o_imem_wdata,
   output logic              o_cpu_rst,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_error,
   output logic [ADDR_W:0]   o_words_loaded
);
   typedef enum logic [2:0] {
      S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA_LO, S_DATA_HI, S_DONE, S_ERROR, S_CHK
   } state_t;

   state_t            r_state, w_next;
   logic [15:0]       r_len, w_len;
   logic [7:0]        r_lo;
   logic [ADDR_W:0]   r_words;
   logic [ADDR_W-1:0] r_addr;
   logic [15:0]       r_wdata;
   logic              r_we, r_rx_ready, r_busy, r_done, r_error, r_cpu_rst;
   logic              w_acc, w_last, w_big, w_load, w_idle;
   state_t            w_fin;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]        r_csum;
   assign w_fin = S_CHK;
`else
   assign w_fin = S_DONE;
`endif

   assign w_acc  = i_rx_valid && r_rx_ready;
   assign w_len  = {i_rx_data, r_len[7:0]};
   assign w_last = 32'(r_words) + 32'd1 == {16'd0, r_len};
   assign w_big  = {16'd0, w_len} > (32'd1 << ADDR_W);
   assign w_idle = r_state == S_IDLE || r_state == S_DONE || r_state == S_ERROR;
   assign w_load = w_next == S_LEN_LO || w_next == S_LEN_HI || w_next == S_DATA_LO ||
                   w_next == S_DATA_HI || w_next == S_CHK;

   // next-state decode; transfers only advance on an accepted byte
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE, S_DONE, S_ERROR: w_next = i_start ? S_LEN_LO : r_state;
         S_LEN_LO:  w_next = w_acc ? S_LEN_HI : r_state;
         S_LEN_HI:  w_next = !w_acc ? r_state : (w_len == 16'd0) ? w_fin : w_big ? S_ERROR : S_DATA_LO;
         S_DATA_LO: w_next = w_acc ? S_DATA_HI : r_state;
         S_DATA_HI: w_next = !w_acc ? r_state : w_last ? w_fin : S_DATA_LO;
`ifdef LOADER_CHECKSUM_EN
         S_CHK:     w_next = !w_acc ? r_state : (i_rx_data == r_csum) ? S_DONE : S_ERROR;
`endif
         default:   w_next = r_state;
      endcase
   end

   // state, registered status outputs and the one-cycle memory write pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_len      <= '0;
         r_lo       <= '0;
         r_words    <= '0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_we       <= 1'b0;
         r_rx_ready <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_error    <= 1'b0;
         r_cpu_rst  <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
         r_csum     <= '0;
`endif
      end else begin
         r_state    <= w_next;
         r_rx_ready <= w_load;
         r_busy     <= w_load;
         r_done     <= w_next == S_DONE;
         r_error    <= w_next == S_ERROR;
         r_cpu_rst  <= w_next != S_DONE;
         r_we       <= 1'b0;
         if (i_start && w_idle) begin
            r_words <= '0;
            r_addr  <= '0;
`ifdef LOADER_CHECKSUM_EN
            r_csum  <= '0;
`endif
         end
`ifdef LOADER_CHECKSUM_EN
         if (w_acc) r_csum <= r_csum ^ i_rx_data;
`endif
         if (w_acc && r_state == S_LEN_LO) r_len[7:0] <= i_rx_data;
         if (w_acc && r_state == S_LEN_HI) r_len[15:8] <= i_rx_data;
         if (w_acc && r_state == S_DATA_LO) r_lo <= i_rx_data;
         if (w_acc && r_state == S_DATA_HI) begin
            r_we    <= 1'b1;
            r_addr  <= r_words[ADDR_W-1:0];
            r_wdata <= {i_rx_data, r_lo};
            r_words <= r_words + (ADDR_W+1)'(1);
         end
      end
   end

   assign o_rx_ready     = r_rx_ready;
   assign o_imem_we      = r_we;
   assign o_imem_addr    = r_addr;
   assign o_imem_wdata   = r_wdata;
   assign o_cpu_rst      = r_cpu_rst;
   assign o_busy         = r_busy;
   assign o_done         = r_done;
   assign o_error        = r_error;
   assign o_words_loaded = r_words;
endmodule
